// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the FSM state encoding and the iteration counter width helper.
package mult_pkg;

    localparam int DEF_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One extra bit so the counter can represent WIDTH itself.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_ctrl.sv
// Control FSM and iteration counter for the shift-add multiplier.
// Ports: clk, rst, start, p_lsb in; load/add/shift/capture/busy/done out.
module mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic p_lsb,
    output logic load,
    output logic add,
    output logic shift,
    output logic capture,
    output logic busy,
    output logic done
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load    = (state_q == ST_IDLE) && start;
        busy    = (state_q == ST_RUN);
        done    = (state_q == ST_DONE);
        add     = busy && p_lsb;
        shift   = busy && !p_lsb;
        // Final iteration: product register takes the step result.
        capture = busy && (cnt_q == LAST);
    end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned shift-add multiplier, one bit of B per cycle.
// Ports: clk, rst, start, multiplicand, multiplier in; busy, done, product out.
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic load, add, shift, capture;

    mult_ctrl #(
        .WIDTH(WIDTH)
    ) u_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .p_lsb  (p_q[0]),
        .load   (load),
        .add    (add),
        .shift  (shift),
        .capture(capture),
        .busy   (busy),
        .done   (done)
    );

    // Ripple-carry adder: upper half of P plus multiplicand, true carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        logic a, b;
        assign a          = p_q[WIDTH+i];
        assign b          = mcand_q[i];
        assign sum[i]     = a ^ b ^ carry[i];
        assign carry[i+1] = (a & b) | (carry[i] & (a ^ b));
    end

    always_comb begin
        mcand_d   = mcand_q;
        p_d       = p_q;
        product_d = product_q;
        if (load) begin
            mcand_d = multiplicand;
            p_d     = {{WIDTH{1'b0}}, multiplier};
        end else if (add) begin
            p_d = {carry[WIDTH], sum, p_q[WIDTH-1:1]};
        end else if (shift) begin
            p_d = {1'b0, p_q[2*WIDTH-1:1]};
        end
        if (capture) begin
            product_d = p_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q   <= '0;
            p_q       <= '0;
            product_q <= '0;
        end else begin
            mcand_q   <= mcand_d;
            p_q       <= p_d;
            product_q <= product_d;
        end
    end

    assign product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier (WIDTH=32).
// Driver pushes expected product and due cycle; monitor pops on done.
module tb_seq_multiplier;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   multiplicand;
    logic [W-1:0]   multiplier;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    seq_multiplier #(
        .WIDTH(W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .multiplicand(multiplicand),
        .multiplier  (multiplier),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*W-1:0] prod;
        int             due;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: done pulses, latency, busy length, product stability.
    int             busy_run = 0;
    int             last_busy_len = 0;
    logic           prev_busy = 1'b0;
    logic [2*W-1:0] held_prod = '0;

    always @(negedge clk) begin
        if (busy) begin
            busy_run++;
            chk("product_stable_run", product, held_prod);
        end else begin
            if (prev_busy) last_busy_len = busy_run;
            busy_run = 0;
        end
        prev_busy = busy;
        if (busy && done) chk("busy_done_exclusive", 1, 0);
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", product, e.prod);
                chk("done_cycle", 64'(cyc), 64'(e.due));
                chk("busy_len", 64'(last_busy_len), 64'(W));
            end
        end
        if (!busy) held_prod = product;
    end

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("wait_idle_timeout", 1, 0);
    endtask

    // Issue one op from an idle negedge; returns the accepting cycle.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit expect_done, input bit hold,
                         output int acc);
        wait_idle();
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        acc = cyc;
        chk("busy_after_accept", 64'(busy), 1);
        if (expect_done) sb.push_back('{64'(a) * 64'(b), cyc + W});
    endtask

    initial begin
        int acc;
        int acc_prev;
        logic [W-1:0] ra, rb;

        rst          = 1'b1;
        start        = 1'b1;
        multiplicand = 32'd99;
        multiplier   = 32'd99;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy), 0);
        chk("reset_done", 64'(done), 0);
        chk("reset_product", product, 0);

        // First start accepted on the first edge with rst low.
        rst          = 1'b0;
        multiplicand = 32'd3;
        multiplier   = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("first_accept", 64'(busy), 1);
        sb.push_back('{64'd15, cyc + W});

        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, acc);
        sb[sb.size()-1].prod = 64'hFFFFFFFE00000001;
        issue(32'h0, 32'h12345678, 1, 0, acc);
        issue(32'h12345678, 32'h0, 1, 0, acc);
        issue(32'h10000, 32'h10000, 1, 0, acc);

        // Start pulsed mid-RUN must be ignored.
        issue(32'd1000, 32'd1000, 1, 0, acc);
        repeat (5) @(negedge clk);
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        issue(32'd2, 32'd3, 1, 0, acc);

        // Reset during RUN aborts with no done pulse.
        issue(32'hDEAD, 32'hBEEF, 0, 0, acc);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_product", product, 0);
        rst = 1'b0;
        issue(32'd7, 32'd9, 1, 0, acc);

        // Start held high: back-to-back ops spaced W+2 cycles.
        acc_prev = 0;
        for (int n = 0; n < 3; n++) begin
            ra = $urandom;
            rb = $urandom;
            issue(ra, rb, 1, n != 2, acc);
            if (n > 0) chk("b2b_spacing", 64'(acc - acc_prev), 64'(W + 2));
            acc_prev = acc;
        end
        start = 1'b0;

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 0);
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
